// File: rtl/mem_access_unit.sv
// Data-memory access unit: aligns and issues one load/store at a time on the
// req/addr_ok/data_ok bus and returns {excp_ale, dcache_ok, mem_result}.
module mem_access_unit (
  input  logic         clk,
  input  logic         reset,
  input  logic [102:0] es_to_ms_bus,
  input  logic         ms_advance,
  output logic [33:0]  ms_to_es_bus,
  output logic         data_req,
  output logic         data_wr,
  output logic [3:0]   data_wstrb,
  output logic [31:0]  data_addr,
  output logic [31:0]  data_wdata,
  input  logic         data_addr_ok,
  input  logic         data_data_ok,
  input  logic [31:0]  data_rdata,
  output logic [1:0]   dbg_state
);

  // Handshake: a request transfers in the cycle where data_req && data_addr_ok;
  // exactly one data_data_ok pulse follows each transferred request, never earlier
  // than the next cycle. Only one request is ever outstanding.
  typedef enum logic [1:0] {IDLE, WAIT_DATA, DONE, DISCARD} state_t;

  state_t state, state_nxt;

  logic [31:0] addr, wdata, pc;
  logic        is_unsigned, mem_we, res_from_mem;
  logic [3:0]  bw;

  assign {addr, is_unsigned, mem_we, res_from_mem, bw, wdata, pc} = es_to_ms_bus;

  logic unused_bits;
  assign unused_bits = bw[3];

  logic access, ale, excp_ale;
  assign access   = mem_we | res_from_mem;
  assign ale      = (bw[1] & addr[0]) | (bw[2] & (addr[1:0] != 2'b00));
  assign excp_ale = access & ale;

  // Store lane formatting
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = wdata;
    if (bw[0]) begin
      st_wstrb = 4'b0001 << addr[1:0];
      st_wdata = {4{wdata[7:0]}};
    end else if (bw[1]) begin
      st_wstrb = 4'b0011 << addr[1:0];
      st_wdata = {2{wdata[15:0]}};
    end else if (bw[2]) begin
      st_wstrb = 4'b1111;
    end
  end

  assign data_wr    = mem_we;
  assign data_addr  = addr;
  assign data_wdata = st_wdata;
  assign data_wstrb = mem_we ? st_wstrb : 4'b0000;

  // Attributes of the accepted access, kept so the response is formatted
  // against the request that produced it.
  logic        wr_q, uns_q;
  logic [31:0] pc_q, result_q;
  logic [1:0]  lane_q;
  logic [2:0]  bw_q;

  logic [31:0] shifted, ld_result;
  assign shifted = data_rdata >> {lane_q, 3'b000};

  always_comb begin
    ld_result = shifted;
    if (bw_q[0])
      ld_result = uns_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
    else if (bw_q[1])
      ld_result = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
  end

  logic flush;
  assign flush = !access || (pc != pc_q);

  logic        dcache_ok, issue, hold_result;
  logic [31:0] mem_result;

  always_comb begin
    state_nxt   = state;
    data_req    = 1'b0;
    dcache_ok   = !access | ale;
    mem_result  = 32'h0;
    issue       = 1'b0;
    hold_result = 1'b0;
    case (state)
      IDLE: begin
        data_req = access & !ale;
        if (data_req && data_addr_ok) begin
          issue     = 1'b1;
          state_nxt = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        // A flushed access never completes; its response is drained instead.
        if (flush) begin
          state_nxt = data_data_ok ? IDLE : DISCARD;
        end else begin
          dcache_ok = data_data_ok;
          if (data_data_ok) begin
            mem_result = wr_q ? 32'h0 : ld_result;
            if (ms_advance) begin
              state_nxt = IDLE;
            end else begin
              state_nxt   = DONE;
              hold_result = 1'b1;
            end
          end
        end
      end
      DONE: begin
        if (flush) begin
          state_nxt = IDLE;
        end else begin
          dcache_ok  = 1'b1;
          mem_result = result_q;
          if (ms_advance) state_nxt = IDLE;
        end
      end
      DISCARD: begin
        if (data_data_ok) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wr_q     <= 1'b0;
      uns_q    <= 1'b0;
      pc_q     <= 32'h0;
      lane_q   <= 2'b00;
      bw_q     <= 3'b000;
      result_q <= 32'h0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        wr_q   <= mem_we;
        uns_q  <= is_unsigned;
        pc_q   <= pc;
        lane_q <= addr[1:0];
        bw_q   <= bw[2:0];
      end
      if (hold_result) result_q <= mem_result;
    end
  end

  assign ms_to_es_bus = {excp_ale, dcache_ok, mem_result};
  assign dbg_state    = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed test-plan cases then randomized ops,
// scored against a byte-lane memory model with request and response queues.
module tb_mem_access_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic [102:0] es_to_ms_bus;
  logic         ms_advance;
  logic [33:0]  ms_to_es_bus;
  logic         data_req, data_wr;
  logic [3:0]   data_wstrb;
  logic [31:0]  data_addr, data_wdata;
  logic         data_addr_ok, data_data_ok;
  logic [31:0]  data_rdata;
  logic [1:0]   dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk          (clk),
    .reset        (reset),
    .es_to_ms_bus (es_to_ms_bus),
    .ms_advance   (ms_advance),
    .ms_to_es_bus (ms_to_es_bus),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .dbg_state    (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [68:0] exp_q[$];  // {wr, wstrb, addr, wdata} per expected request
  logic [33:0] rsp_q[$];  // {needs_mem, excp_ale, mem_result} per retiring access

  int          fixed_dly   = -1;
  int          addr_ok_pct = 100;
  logic        rd_force_en = 1'b0;
  logic [31:0] rd_force    = 32'h0;
  int          hs_cnt      = 0;
  int          stale_req   = 0;
  int          stale_done  = 0;

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] load_model(input logic [31:0] word, input logic [31:0] a,
                                             input int w, input bit uns);
    int    nbits;
    longint v;
    nbits = 8 << w;
    v = longint'(word >> (8 * a[1:0])) % (longint'(1) << nbits);
    if (!uns && v >= (longint'(1) << (nbits - 1))) v = v - (longint'(1) << nbits);
    return v[31:0];
  endfunction

  function automatic logic [68:0] req_model(input logic [31:0] a, input int w,
                                            input logic [31:0] wd, input bit we);
    logic [3:0]  strb;
    logic [31:0] d;
    int          sz;
    sz   = 1 << w;
    strb = 4'b0000;
    for (int i = 0; i < sz; i++)
      if (int'(a[1:0]) + i < 4) strb[int'(a[1:0]) + i] = 1'b1;
    for (int b = 0; b < 4; b++) d[8*b +: 8] = wd[8*(b % sz) +: 8];
    if (!we) strb = 4'b0000;
    return {we, strb, a, d};
  endfunction

  // ---------------- memory responder ----------------
  initial begin : mem_model
    bit          pend;
    int          dly;
    logic [31:0] rd;
    pend = 0; dly = 0; rd = 32'h0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 0;
      end else begin
        if (data_data_ok) pend = 0;
        if (data_req && data_addr_ok) begin
          pend = 1;
          dly  = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 2));
          rd   = rd_force_en ? rd_force : mem_word(data_addr);
        end
      end
      @(posedge clk); #1;
      data_addr_ok = ($urandom_range(1, 100) <= addr_ok_pct);
      if (pend && dly == 0) begin
        data_data_ok = 1'b1;
        data_rdata   = rd;
      end else begin
        data_data_ok = 1'b0;
        data_rdata   = $urandom;
        if (pend) dly--;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int          outstanding = 0;
  bit          front_seen  = 0;
  logic        m_acc, m_ale;
  int          m_sz;
  logic [33:0] m_e;

  always @(negedge clk) begin
    if (reset) begin
      outstanding = 0;
      front_seen  = 0;
    end else begin
      m_acc = es_to_ms_bus[69] | es_to_ms_bus[68];
      m_sz  = es_to_ms_bus[66] ? 4 : (es_to_ms_bus[65] ? 2 : 1);
      m_ale = m_acc && ((es_to_ms_bus[102:71] % m_sz) != 0);
      if (outstanding > 0) check("req_while_busy", data_req, 1'b0);
      if (data_req && data_addr_ok) begin
        hs_cnt++;
        if (exp_q.size() == 0) check("unexpected_req", 1'b1, 1'b0);
        else check("req_fields", {data_wr, data_wstrb, data_addr, data_wdata}, exp_q.pop_front());
        outstanding++;
      end
      if (data_data_ok) begin
        if (outstanding > 0) outstanding--;
        if (stale_req > stale_done) begin
          stale_done++;
          if (m_acc && !m_ale) check("discard_dcache_ok", ms_to_es_bus[32], 1'b0);
        end
      end
      if (m_acc && ms_to_es_bus[32] && rsp_q.size() > 0) begin
        m_e = rsp_q[0];
        if (m_e[33] && !front_seen) check("complete_with_data_ok", data_data_ok, 1'b1);
        front_seen = 1;
        check("response", {ms_to_es_bus[33], ms_to_es_bus[31:0]}, m_e[32:0]);
        if (ms_advance) begin
          void'(rsp_q.pop_front());
          front_seen = 0;
        end
      end
      if (m_acc && !ms_to_es_bus[32]) check("no_early_excp", ms_to_es_bus[33], 1'b0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_op(input logic [31:0] a, input int w, input bit we, input bit ld,
                       input bit uns, input logic [31:0] wd, input logic [31:0] pc,
                       input int hold);
    bit          acc, ale;
    logic [31:0] word;
    int          h;
    h    = hold;
    acc  = we | ld;
    ale  = acc && (w > 0) && ((a % (1 << w)) != 0);
    word = rd_force_en ? rd_force : mem_word(a);
    if (acc && !ale) exp_q.push_back(req_model(a, w, wd, we));
    if (acc) rsp_q.push_back({!ale, ale, (ale || we) ? 32'h0 : load_model(word, a, w, uns)});
    @(posedge clk); #1;
    es_to_ms_bus = {a, uns, we, ld, 4'(1 << w), wd, pc};
    ms_advance   = 1'b0;
    for (int cyc = 0; ; cyc++) begin
      #1;
      if (ms_to_es_bus[32]) begin
        if (h == 0) begin
          ms_advance = 1'b1;
          break;
        end
        h--;
      end
      if (cyc >= 60) begin
        check("op_timeout", 1'b0, 1'b1);
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // Word load that is accepted and then withdrawn before its response returns.
  task automatic withdraw_op(input logic [31:0] a, input logic [31:0] pc);
    int start;
    start = hs_cnt;
    exp_q.push_back(req_model(a, 2, 32'h0, 1'b0));
    fixed_dly = 3;
    @(posedge clk); #1;
    es_to_ms_bus = {a, 1'b0, 1'b0, 1'b1, 4'b0100, 32'h0, pc};
    ms_advance   = 1'b0;
    for (int cyc = 0; hs_cnt == start; cyc++) begin
      if (cyc >= 60) begin
        check("withdraw_timeout", 1'b0, 1'b1);
        break;
      end
      @(negedge clk); #1;
    end
    fixed_dly = -1;
    stale_req++;
    @(posedge clk); #1;
    es_to_ms_bus = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] a, pc;
    int          kind, w;
    reset        = 1'b1;
    ms_advance   = 1'b0;
    es_to_ms_bus = {32'h1000, 1'b0, 1'b0, 1'b1, 4'b0100, 32'h0, 32'h100};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_aligned_load", data_req, 1'b1);
    check("reset_bus_aligned_load", ms_to_es_bus, 34'h0);
    es_to_ms_bus = '0;
    #1;
    check("reset_req_idle", data_req, 1'b0);
    check("reset_bus_idle", ms_to_es_bus, {1'b0, 1'b1, 32'h0});
    @(posedge clk); #1;
    reset = 1'b0;

    // directed cases
    fixed_dly = 0; addr_ok_pct = 100; rd_force_en = 1'b1;
    rd_force = 32'hDEADBEEF;
    do_op(32'h1000, 2, 0, 1, 0, 32'h0, 32'h100, 0);
    rd_force = 32'h80123456;
    do_op(32'h1003, 0, 0, 1, 0, 32'h0, 32'h104, 0);
    do_op(32'h1003, 0, 0, 1, 1, 32'h0, 32'h108, 0);
    rd_force_en = 1'b0;
    do_op(32'h2002, 1, 1, 0, 0, 32'h0000ABCD, 32'h10C, 0);
    do_op(32'h1001, 2, 0, 1, 0, 32'h0, 32'h110, 0);
    do_op(32'h3000, 2, 1, 0, 0, 32'h12345678, 32'h114, 3);
    fixed_dly = -1; addr_ok_pct = 40;
    do_op(32'h3006, 1, 0, 1, 0, 32'h0, 32'h118, 0);
    withdraw_op(32'h4000, 32'h11C);
    do_op(32'h4004, 2, 0, 1, 0, 32'h0, 32'h120, 0);

    // randomized ops
    addr_ok_pct = 65;
    pc = 32'h8000;
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      w    = $urandom_range(0, 2);
      a    = $urandom;
      if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << w) - 32'd1);
      pc   = pc + 32'd4;
      if (kind == 0)
        do_op(a, w, 0, 0, 0, $urandom, pc, 0);
      else if (kind == 1)
        withdraw_op(a & 32'hFFFFFFFC, pc);
      else
        do_op(a, w, kind[0], !kind[0], $urandom_range(0, 1), $urandom, pc,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    @(posedge clk); #1;
    es_to_ms_bus = '0;
    ms_advance   = 1'b0;
    repeat (10) @(negedge clk);
    check("requests_drained", 69'(exp_q.size()), 69'd0);
    check("responses_drained", 69'(rsp_q.size()), 69'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
